// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and MEM-stage access; MEM wins.
// Optional perf counters enabled by defining MEM_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall_all,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              bus_err,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       txn_cnt
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, MEM_BUSY, IF_BUSY} state_e;

  state_e            state_q;
  logic              mem_done_q, if_done_q;
  logic [CNT_W-1:0]  to_cnt_q;
  logic              m_req_q, m_we_q, bus_err_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q, if_rdata_q, mem_rdata_q;

  logic mem_pend, if_pend, to_hit;

  assign mem_pend  = (mem_read | mem_write) & ~mem_done_q;
  assign if_pend   = if_req & ~if_done_q;
  assign stall_all = mem_pend | if_pend;
  assign to_hit    = (to_cnt_q == CNT_W'(TIMEOUT - 1));

  // Arbitration FSM; done flags hold a served requester off until the pipeline advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_done_q  <= 1'b0;
      if_done_q   <= 1'b0;
      to_cnt_q    <= '0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!stall_all) begin
            mem_done_q <= 1'b0;
            if_done_q  <= 1'b0;
          end
          if (mem_pend) begin
            state_q   <= MEM_BUSY;
            m_req_q   <= 1'b1;
            m_we_q    <= mem_write;
            m_addr_q  <= mem_addr;
            m_wdata_q <= mem_wdata;
            to_cnt_q  <= '0;
          end else if (if_pend) begin
            state_q  <= IF_BUSY;
            m_req_q  <= 1'b1;
            m_we_q   <= 1'b0;
            m_addr_q <= if_addr;
            to_cnt_q <= '0;
          end
        end
        MEM_BUSY: begin
          if (m_ack) begin
            m_req_q    <= 1'b0;
            mem_done_q <= 1'b1;
            if (!m_we_q) mem_rdata_q <= m_rdata;
            state_q    <= IDLE;
          end else if (to_hit) begin
            m_req_q     <= 1'b0;
            mem_done_q  <= 1'b1;
            mem_rdata_q <= '0;
            bus_err_q   <= 1'b1;
            state_q     <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
          end
        end
        IF_BUSY: begin
          if (m_ack) begin
            m_req_q    <= 1'b0;
            if_done_q  <= 1'b1;
            if_rdata_q <= m_rdata;
            state_q    <= IDLE;
          end else if (to_hit) begin
            m_req_q    <= 1'b0;
            if_done_q  <= 1'b1;
            if_rdata_q <= '0;
            bus_err_q  <= 1'b1;
            state_q    <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign bus_err   = bus_err_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

`ifdef MEM_ARB_PERF_EN
  logic        txn_end;
  logic [31:0] stall_cnt_q, txn_cnt_q;

  assign txn_end = (state_q != IDLE) & (m_ack | to_hit);

  // Free-running perf counters, wrap naturally at 32 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      txn_cnt_q   <= '0;
    end else begin
      if (stall_all) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (txn_end)   txn_cnt_q   <= txn_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign txn_cnt   = txn_cnt_q;
`else
  assign stall_cnt = '0;
  assign txn_cnt   = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT=4 instance).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_read, mem_write, m_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, m_rdata;
  logic [31:0] if_rdata, mem_rdata, m_addr, m_wdata, stall_cnt, txn_cnt;
  logic        stall_all, m_req, m_we, bus_err;

  int n_vec = 0;
  int n_err = 0;
  int stall_seen = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_all(stall_all),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .bus_err(bus_err), .stall_cnt(stall_cnt), .txn_cnt(txn_cnt)
  );

  // Stall cycles observed mid-cycle
  always @(negedge clk) if (!rst && stall_all) stall_seen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 0; mem_read = 0; mem_write = 0; m_ack = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; m_rdata = '0;
    #2;
    n_vec++; if (m_req !== 1'b0) begin n_err++; $display("FAIL rst_mreq got %b exp 0", m_req); end
    n_vec++; if (stall_all !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b exp 0", stall_all); end
    n_vec++; if ({bus_err, m_we} !== 2'b00) begin n_err++; $display("FAIL rst_flags got %b exp 00", {bus_err, m_we}); end
    n_vec++; if ({if_rdata, mem_rdata, m_addr} !== 96'd0) begin n_err++; $display("FAIL rst_data got %h exp 0", {if_rdata, mem_rdata, m_addr}); end
    n_vec++; if ({stall_cnt, txn_cnt} !== 64'd0) begin n_err++; $display("FAIL rst_perf got %h exp 0", {stall_cnt, txn_cnt}); end
    #10 rst = 1'b0;
    tick(); tick();
    n_vec++; if ({m_req, stall_all} !== 2'b00) begin n_err++; $display("FAIL idle_quiet got %b exp 00", {m_req, stall_all}); end
  endtask

  task automatic test_fetch();
    int base;
    base = stall_seen;
    if_req = 1; if_addr = 32'h40;
    #1;
    n_vec++; if (stall_all !== 1'b1) begin n_err++; $display("FAIL f_stall0 got %b exp 1", stall_all); end
    tick();
    n_vec++; if (m_req !== 1'b1) begin n_err++; $display("FAIL f_mreq got %b exp 1", m_req); end
    n_vec++; if (m_addr !== 32'h40) begin n_err++; $display("FAIL f_addr got %h exp 00000040", m_addr); end
    n_vec++; if (m_we !== 1'b0) begin n_err++; $display("FAIL f_we got %b exp 0", m_we); end
    m_ack = 1; m_rdata = 32'h8C010004;
    tick();
    m_ack = 0;
    n_vec++; if (stall_all !== 1'b0) begin n_err++; $display("FAIL f_adv got %b exp 0", stall_all); end
    n_vec++; if (if_rdata !== 32'h8C010004) begin n_err++; $display("FAIL f_rdata got %h exp 8c010004", if_rdata); end
    n_vec++; if (m_req !== 1'b0) begin n_err++; $display("FAIL f_mreq_drop got %b exp 0", m_req); end
    if_req = 0;
    tick();
    n_vec++; if (stall_seen - base !== 2) begin n_err++; $display("FAIL f_stall_len got %0d exp 2", stall_seen - base); end
  endtask

  task automatic test_lw_fetch();
    int base;
    base = stall_seen;
    mem_read = 1; mem_addr = 32'h100; if_req = 1; if_addr = 32'h44;
    tick();
    n_vec++; if ({m_req, m_we} !== 2'b10) begin n_err++; $display("FAIL lw_req got %b exp 10", {m_req, m_we}); end
    n_vec++; if (m_addr !== 32'h100) begin n_err++; $display("FAIL lw_addr got %h exp 00000100", m_addr); end
    tick();
    m_ack = 1; m_rdata = 32'h11112222;
    tick();
    m_ack = 0;
    n_vec++; if (mem_rdata !== 32'h11112222) begin n_err++; $display("FAIL lw_rdata got %h exp 11112222", mem_rdata); end
    n_vec++; if ({m_req, stall_all} !== 2'b01) begin n_err++; $display("FAIL lw_gap got %b exp 01", {m_req, stall_all}); end
    tick();
    n_vec++; if (m_addr !== 32'h44 || m_req !== 1'b1) begin n_err++; $display("FAIL lw_if_addr got %h/%b exp 00000044/1", m_addr, m_req); end
    tick();
    m_ack = 1; m_rdata = 32'h22223333;
    tick();
    m_ack = 0;
    n_vec++; if (if_rdata !== 32'h22223333) begin n_err++; $display("FAIL lw_if_rdata got %h exp 22223333", if_rdata); end
    n_vec++; if (mem_rdata !== 32'h11112222) begin n_err++; $display("FAIL lw_rdata_hold got %h exp 11112222", mem_rdata); end
    n_vec++; if (stall_all !== 1'b0) begin n_err++; $display("FAIL lw_adv got %b exp 0", stall_all); end
    mem_read = 0; if_req = 0;
    tick();
    n_vec++; if (stall_seen - base !== 6) begin n_err++; $display("FAIL lw_stall_len got %0d exp 6", stall_seen - base); end
  endtask

  task automatic test_perf();
    logic [31:0] s0, t0;
    s0 = stall_cnt; t0 = txn_cnt;
    test_lw_fetch();
`ifdef MEM_ARB_PERF_EN
    n_vec++; if (stall_cnt - s0 !== 32'd6) begin n_err++; $display("FAIL perf_stall got %0d exp 6", stall_cnt - s0); end
    n_vec++; if (txn_cnt - t0 !== 32'd2) begin n_err++; $display("FAIL perf_txn got %0d exp 2", txn_cnt - t0); end
`else
    n_vec++; if (stall_cnt !== 32'd0 || s0 !== 32'd0) begin n_err++; $display("FAIL perf_stall_off got %h exp 0", stall_cnt); end
    n_vec++; if (txn_cnt !== 32'd0 || t0 !== 32'd0) begin n_err++; $display("FAIL perf_txn_off got %h exp 0", txn_cnt); end
`endif
  endtask

  task automatic test_store();
    mem_write = 1; mem_addr = 32'h104; mem_wdata = 32'hDEADBEEF;
    tick();
    n_vec++; if ({m_req, m_we} !== 2'b11) begin n_err++; $display("FAIL sw_req got %b exp 11", {m_req, m_we}); end
    n_vec++; if (m_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_wdata got %h exp deadbeef", m_wdata); end
    n_vec++; if (m_addr !== 32'h104) begin n_err++; $display("FAIL sw_addr got %h exp 00000104", m_addr); end
    m_ack = 1; m_rdata = 32'hBAD0BAD0;
    tick();
    m_ack = 0;
    n_vec++; if (mem_rdata !== 32'h11112222) begin n_err++; $display("FAIL sw_rdata_hold got %h exp 11112222", mem_rdata); end
    n_vec++; if ({m_req, stall_all} !== 2'b00) begin n_err++; $display("FAIL sw_done got %b exp 00", {m_req, stall_all}); end
    mem_write = 0;
    tick();
  endtask

  task automatic test_timeout();
    int base;
    base = stall_seen;
    mem_read = 1; mem_addr = 32'h200;
    tick(); tick(); tick(); tick();
    n_vec++; if ({m_req, bus_err} !== 2'b10) begin n_err++; $display("FAIL to_busy4 got %b exp 10", {m_req, bus_err}); end
    tick();
    n_vec++; if ({m_req, bus_err} !== 2'b01) begin n_err++; $display("FAIL to_abort got %b exp 01", {m_req, bus_err}); end
    n_vec++; if (mem_rdata !== 32'd0) begin n_err++; $display("FAIL to_rdata got %h exp 0", mem_rdata); end
    n_vec++; if (stall_all !== 1'b0) begin n_err++; $display("FAIL to_release got %b exp 0", stall_all); end
    mem_read = 0;
    tick();
    n_vec++; if (stall_seen - base !== 5) begin n_err++; $display("FAIL to_stall_len got %0d exp 5", stall_seen - base); end
    n_vec++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL to_sticky got %b exp 1", bus_err); end
  endtask

  task automatic test_async_reset();
    mem_read = 1; mem_addr = 32'h300;
    tick();
    n_vec++; if (m_req !== 1'b1) begin n_err++; $display("FAIL ar_busy got %b exp 1", m_req); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (m_req !== 1'b0) begin n_err++; $display("FAIL ar_mreq got %b exp 0", m_req); end
    n_vec++; if ({stall_all, bus_err} !== 2'b10) begin n_err++; $display("FAIL ar_stall got %b exp 10", {stall_all, bus_err}); end
    mem_read = 0;
    #1;
    n_vec++; if (stall_all !== 1'b0) begin n_err++; $display("FAIL ar_follow got %b exp 0", stall_all); end
    rst = 1'b0;
    tick();
    m_ack = 1; m_rdata = 32'h55555555;
    tick();
    m_ack = 0;
    n_vec++; if ({m_req, stall_all} !== 2'b00) begin n_err++; $display("FAIL ar_late_ack got %b exp 00", {m_req, stall_all}); end
    n_vec++; if ({mem_rdata, if_rdata} !== 64'd0) begin n_err++; $display("FAIL ar_rdata got %h exp 0", {mem_rdata, if_rdata}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_perf();
    test_store();
    test_timeout();
    test_async_reset();
    test_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
